// File: rtl/attn_out_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : attn_out_pack_pkg
// Description : Shared types and helpers for the attention-output packer.
//               It holds the frame-state encoding, the lane geometry and the
//               byte-valid mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package attn_out_pack_pkg;

  // Number of elements packed into one output word, and the lane index width
  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  // Frame tracking: IDLE means no element of the current frame has been seen
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } frame_state_e;

  // Byte-valid mask for a word whose final element sits in 'lane':
  // (1 << (lane+1)) - 1, written out so that no shift overflow can occur
  function automatic logic [LANES-1:0] lane_mask(input logic [LANE_W-1:0] lane);
    logic [LANES-1:0] mask;
    mask = '0;
    case (lane)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0011;
      2'd2:    mask = 4'b0111;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage : attn_out_pack_pkg
`default_nettype wire

// File: rtl/attn_out_pack_axis_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : axis_out_reg
// Description : Single-entry AXI-Stream output register. A load captures a
//               word and raises valid; the word is held unchanged until the
//               downstream ready completes the transfer. A load arriving in
//               the same cycle as a transfer replaces the word and keeps the
//               register full.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_out_reg #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [KEEP_W-1:0] load_keep,
  input  logic              load_last,
  output logic [DATA_W-1:0] tdata,
  output logic [KEEP_W-1:0] tkeep,
  output logic              tlast,
  output logic              tvalid,
  input  logic              tready,
  output logic              full
);

  // The upstream only loads when the register is empty or draining this
  // cycle, so a load always wins over a pending transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tdata  <= '0;
      tkeep  <= '0;
      tlast  <= 1'b0;
      tvalid <= 1'b0;
    end else if (load) begin
      tdata  <= load_data;
      tkeep  <= load_keep;
      tlast  <= load_last;
      tvalid <= 1'b1;
    end else if (tvalid && tready) begin
      tvalid <= 1'b0;
    end
  end

  assign full = tvalid;

endmodule : axis_out_reg
`default_nettype wire

// File: rtl/attn_out_pack.sv
`default_nettype none
// ============================================================================
// Module      : attn_out_pack
// Description : Packs a stream of signed int8 attention-head output elements
//               into 32-bit little-endian words for a DMA S2MM channel.
//               Partial final words are zero-padded with a matching tkeep.
//               A frame FSM counts elements, checks the frame length against
//               an optional expected value (sticky error) and counts emitted
//               frames.
// Revision    : 1.0 - initial release
// ============================================================================
module attn_out_pack
  import attn_out_pack_pkg::*;
#(
  parameter int D_W          = 8,
  parameter int OUT_W        = 32,   // must equal LANES * D_W
  parameter int MATRIXSIZE_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  // Element stream from the attention head
  input  logic signed [D_W-1:0]   s_tdata,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  // Packed stream to the DMA S2MM channel
  output logic [OUT_W-1:0]        m_axis_s2mm_tdata,
  output logic [OUT_W/8-1:0]      m_axis_s2mm_tkeep,
  output logic                    m_axis_s2mm_tlast,
  output logic                    m_axis_s2mm_tvalid,
  input  logic                    m_axis_s2mm_tready,
  // Frame bookkeeping
  input  logic [MATRIXSIZE_W-1:0] expected_len,
  output logic                    err_len,
  output logic [MATRIXSIZE_W-1:0] frame_cnt
);

  localparam int KEEP_W = OUT_W / 8;

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  logic                    out_full;
  logic                    in_xfer;
  logic                    out_xfer;
  logic                    word_done;
  logic [D_W-1:0]          elem;

  logic [LANE_W-1:0]       lane;
  logic [LANES-2:0][D_W-1:0] asm_bytes;
  logic [OUT_W-1:0]        word;
  logic [KEEP_W-1:0]       word_keep;

  // Ready is gated by reset so nothing is accepted while the block is held
  assign s_tready  = rst & (~out_full | m_axis_s2mm_tready);
  assign in_xfer   = s_tvalid & s_tready;
  assign out_xfer  = m_axis_s2mm_tvalid & m_axis_s2mm_tready;
  assign elem      = s_tdata;

  // A word closes on the top lane or on the frame's last element
  assign word_done = in_xfer & ((lane == LANE_W'(LANES - 1)) | s_tlast);

  // --------------------------------------------------------------------------
  // Lane counter and assembly register
  // --------------------------------------------------------------------------

  // Lane advances per stored element and returns to 0 when a word closes
  always_ff @(posedge clk) begin
    if (!rst) begin
      lane <= '0;
    end else if (word_done) begin
      lane <= '0;
    end else if (in_xfer) begin
      lane <= lane + LANE_W'(1);
    end
  end

  // Each non-final lane has its own byte register, written only while open
  for (genvar k = 0; k < LANES - 1; k++) begin : g_asm
    // Capture the element arriving in lane k when it does not close the word
    always_ff @(posedge clk) begin
      if (!rst) begin
        asm_bytes[k] <= '0;
      end else if (in_xfer && !word_done && (lane == LANE_W'(k))) begin
        asm_bytes[k] <= elem;
      end
    end
  end

  // Completed word: stored lanes below the current one, the live element in
  // the current lane, and zeros above it. Stale bytes from an earlier word
  // are masked by the lane comparison, so the assembly needs no clearing.
  for (genvar k = 0; k < LANES; k++) begin : g_word
    if (k < LANES - 1) begin : g_stored
      assign word[k*D_W +: D_W] = (lane == LANE_W'(k)) ? elem :
                                  (LANE_W'(k) < lane)  ? asm_bytes[k] :
                                                         {D_W{1'b0}};
    end else begin : g_top
      assign word[k*D_W +: D_W] = (lane == LANE_W'(k)) ? elem : {D_W{1'b0}};
    end
  end

  assign word_keep = lane_mask(lane);

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  axis_out_reg #(
    .DATA_W (OUT_W),
    .KEEP_W (KEEP_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (word_done),
    .load_data (word),
    .load_keep (word_keep),
    .load_last (s_tlast),
    .tdata     (m_axis_s2mm_tdata),
    .tkeep     (m_axis_s2mm_tkeep),
    .tlast     (m_axis_s2mm_tlast),
    .tvalid    (m_axis_s2mm_tvalid),
    .tready    (m_axis_s2mm_tready),
    .full      (out_full)
  );

  // --------------------------------------------------------------------------
  // Frame FSM and length check
  // --------------------------------------------------------------------------
  frame_state_e            state;
  frame_state_e            next_state;
  logic                    frame_start;
  logic                    frame_end;
  logic [MATRIXSIZE_W-1:0] len_q;
  logic [MATRIXSIZE_W-1:0] active_len;
  logic [MATRIXSIZE_W-1:0] elem_cnt;
  logic [MATRIXSIZE_W-1:0] cnt_next;
  logic                    len_bad;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: a one-element frame starts and ends in the same cycle and
  // therefore never leaves IDLE
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (in_xfer && !s_tlast) next_state = ST_FILL;
      ST_FILL: if (in_xfer &&  s_tlast) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: the first element's check must use the live expected_len,
  // because the latched copy only becomes valid on the following cycle
  always_comb begin
    frame_start = (state == ST_IDLE) & in_xfer;
    frame_end   = in_xfer & s_tlast;
    active_len  = (state == ST_IDLE) ? expected_len : len_q;
  end

  assign cnt_next = elem_cnt + MATRIXSIZE_W'(1);

  // A zero length disables the check; otherwise tlast must land exactly on
  // the expected count and no earlier element may reach it
  assign len_bad = in_xfer & (active_len != '0) &
                   (s_tlast ? (cnt_next != active_len) : (cnt_next == active_len));

  // Latch the frame length at the first accepted element
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q <= '0;
    end else if (frame_start) begin
      len_q <= expected_len;
    end
  end

  // Per-frame element counter, cleared as the frame returns to IDLE
  always_ff @(posedge clk) begin
    if (!rst) begin
      elem_cnt <= '0;
    end else if (frame_end) begin
      elem_cnt <= '0;
    end else if (in_xfer) begin
      elem_cnt <= cnt_next;
    end
  end

  // Sticky length error; observation only, never touches the data path
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_len <= 1'b0;
    end else if (len_bad) begin
      err_len <= 1'b1;
    end
  end

  // Frames are counted when their last word actually leaves the block
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (out_xfer && m_axis_s2mm_tlast) begin
      frame_cnt <= frame_cnt + MATRIXSIZE_W'(1);
    end
  end

endmodule : attn_out_pack
`default_nettype wire
